// File: rtl/cross_bar_slave_arbiter.sv
// Per-slave round-robin arbiter: grants one master for a whole transaction and
// releases on completion or when the slave stops responding for TIMEOUT_CYC cycles.
module cross_bar_slave_arbiter #(
    parameter int MASTER_N    = 4,
    parameter int MASTER_W    = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MASTER_N-1:0] m_req,
    input  logic [MASTER_N-1:0] m_cmd,
    input  logic                s_ack,
    input  logic                s_resp,
    output logic [MASTER_N-1:0] grant,
    output logic [MASTER_W:0]   grant_num,
    output logic                s_req,
    output logic                s_cmd,
    output logic [MASTER_N-1:0] m_ack,
    output logic [MASTER_N-1:0] m_resp,
    output logic                timeout
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [MASTER_W:0] NO_GRANT = (MASTER_W+1)'(1) << MASTER_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [MASTER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [MASTER_W-1:0] win_q, win_d;
    logic [MASTER_N-1:0] grant_q, grant_d;
    logic [MASTER_W:0]   grant_num_q, grant_num_d;
    logic                s_cmd_q, s_cmd_d;
    logic                timeout_q, timeout_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic                found;
    logic [MASTER_W-1:0] pick;
    logic [MASTER_W:0]   sum;
    logic                go_rel;

    // Round-robin search: first requester at or above rr_ptr, wrapping at MASTER_N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            sum = {1'b0, rr_ptr_q} + (MASTER_W+1)'(i);
            if (sum >= (MASTER_W+1)'(MASTER_N)) begin
                sum = sum - (MASTER_W+1)'(MASTER_N);
            end
            if (!found && m_req[sum[MASTER_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[MASTER_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        grant_d     = grant_q;
        grant_num_d = grant_num_q;
        s_cmd_d     = s_cmd_q;
        timer_d     = timer_q;
        timeout_d   = 1'b0;
        go_rel      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d     = ST_WAIT_ACK;
                    win_d       = pick;
                    grant_d     = MASTER_N'(1) << pick;
                    grant_num_d = {1'b0, pick};
                    s_cmd_d     = m_cmd[pick];
                    timer_d     = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (s_ack) begin
                    timer_d = '0;
                    if (s_cmd_q) begin
                        go_rel = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    go_rel    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_RESP: begin
                if (s_resp) begin
                    go_rel = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    go_rel    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                if (win_q == MASTER_W'(MASTER_N - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Grant is dropped on entry to RELEASE so the release cycle shows no owner.
        if (go_rel) begin
            state_d     = ST_RELEASE;
            grant_d     = '0;
            grant_num_d = NO_GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            grant_q     <= '0;
            grant_num_q <= NO_GRANT;
            s_cmd_q     <= 1'b0;
            timeout_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            grant_num_q <= grant_num_d;
            s_cmd_q     <= s_cmd_d;
            timeout_q   <= timeout_d;
            timer_q     <= timer_d;
        end
    end

    assign grant     = grant_q;
    assign grant_num = grant_num_q;
    assign s_req     = (state_q == ST_WAIT_ACK);
    assign s_cmd     = s_cmd_q;
    assign timeout   = timeout_q;
    // Slave handshakes are routed only while the matching wait state is active.
    assign m_ack     = (state_q == ST_WAIT_ACK  && s_ack)  ? grant_q : '0;
    assign m_resp    = (state_q == ST_WAIT_RESP && s_resp) ? grant_q : '0;

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// Bench for cross_bar_slave_arbiter: directed table, hand-written corner sequences
// and randomized transactions against a transaction-level round-robin model.
module tb_cross_bar_slave_arbiter;

    localparam int T = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] m_req;
    logic [3:0] m_cmd;
    logic       s_ack;
    logic       s_resp;
    logic [3:0] grant;
    logic [2:0] grant_num;
    logic       s_req;
    logic       s_cmd;
    logic [3:0] m_ack;
    logic [3:0] m_resp;
    logic       timeout;

    cross_bar_slave_arbiter #(
        .MASTER_N   (4),
        .MASTER_W   (2),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_cmd    (m_cmd),
        .s_ack    (s_ack),
        .s_resp   (s_resp),
        .grant    (grant),
        .grant_num(grant_num),
        .s_req    (s_req),
        .s_cmd    (s_cmd),
        .m_ack    (m_ack),
        .m_resp   (m_resp),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass;
    int n_tot;
    int ptr;
    int grant_cyc;

    typedef struct {
        logic [3:0] req;
        logic [3:0] cmd;
        int         exp_w;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester from the pointer upward, modulo 4.
    function automatic int winner(input int p, input logic [3:0] req);
        int j;
        for (int i = 0; i < 4; i++) begin
            j = (p + i) % 4;
            if (req[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic idle_cycle(input bit noise);
        m_req  = 4'b0000;
        s_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        chk("idle_grant", grant, 4'b0000);
        chk("idle_num_msb", grant_num[2], 1'b1);
        chk("idle_sreq", s_req, 1'b0);
        chk("idle_mack", m_ack, 4'b0000);
        chk("idle_mresp", m_resp, 4'b0000);
        tick();
        s_ack  = 1'b0;
        s_resp = 1'b0;
    endtask

    // One full transaction starting in an IDLE cycle; d/r = ack/resp delay in wait cycles.
    task automatic txn(input logic [3:0] req, input logic [3:0] cmd, input int exp_w,
                       input int d, input int r, input bit noise);
        logic [3:0] oh;
        bit         is_wr;
        bit         to;
        bit         done;
        oh    = 4'b0001 << exp_w;
        is_wr = cmd[exp_w];
        to    = 1'b0;
        m_req  = req;
        m_cmd  = cmd;
        s_ack  = 1'b0;
        s_resp = 1'b0;
        #1;
        chk("pre_grant", grant, 4'b0000);
        chk("pre_sreq", s_req, 1'b0);
        tick();
        grant_cyc = cyc;
        chk("grant", grant, oh);
        chk("grant_num", grant_num, 3'(exp_w));
        chk("s_cmd", s_cmd, is_wr);
        for (int k = 0; k < T; k++) begin
            if (noise) m_req = 4'($urandom);
            s_ack  = (k == d);
            s_resp = noise ? 1'($urandom_range(0, 1)) : (k == d);
            #1;
            chk("wa_sreq", s_req, 1'b1);
            chk("wa_grant", grant, oh);
            chk("wa_mack", m_ack, (k == d) ? oh : 4'b0000);
            chk("wa_mresp", m_resp, 4'b0000);
            chk("wa_timeout", timeout, 1'b0);
            done = (k == d);
            if (!done && k == T - 1) to = 1'b1;
            tick();
            if (done || to) break;
        end
        s_ack  = 1'b0;
        s_resp = 1'b0;
        if (!to && !is_wr) begin
            for (int k = 0; k < T; k++) begin
                if (noise) m_req = 4'($urandom);
                s_resp = (k == r);
                #1;
                chk("wr_sreq", s_req, 1'b0);
                chk("wr_grant", grant, oh);
                chk("wr_mresp", m_resp, (k == r) ? oh : 4'b0000);
                chk("wr_mack", m_ack, 4'b0000);
                chk("wr_timeout", timeout, 1'b0);
                done = (k == r);
                if (!done && k == T - 1) to = 1'b1;
                tick();
                if (done || to) break;
            end
        end
        s_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        chk("rel_grant", grant, 4'b0000);
        chk("rel_num_msb", grant_num[2], 1'b1);
        chk("rel_sreq", s_req, 1'b0);
        chk("rel_timeout", timeout, to);
        chk("rel_mack", m_ack, 4'b0000);
        chk("rel_mresp", m_resp, 4'b0000);
        tick();
        s_ack  = 1'b0;
        s_resp = 1'b0;
        m_req  = 4'b0000;
        ptr    = (exp_w + 1) % 4;
    endtask

    initial begin
        int prev;
        int w;
        logic [3:0] rq;
        n_pass = 0;
        n_tot  = 0;
        ptr    = 0;
        tbl[0] = '{4'hF, 4'hF, 0};
        tbl[1] = '{4'hF, 4'hF, 1};
        tbl[2] = '{4'hF, 4'hF, 2};
        tbl[3] = '{4'hF, 4'hF, 3};
        tbl[4] = '{4'hF, 4'hF, 0};
        tbl[5] = '{4'b1001, 4'hF, 3};
        tbl[6] = '{4'b0110, 4'hF, 1};
        tbl[7] = '{4'b0011, 4'hF, 0};
        tbl[8] = '{4'b1000, 4'hF, 3};
        tbl[9] = '{4'b0001, 4'hF, 0};

        rst_n  = 1'b0;
        m_req  = 4'hF;
        m_cmd  = 4'hF;
        s_ack  = 1'b0;
        s_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", grant, 4'b0000);
            chk("rst_num", grant_num, 3'b100);
            chk("rst_sreq", s_req, 1'b0);
            chk("rst_timeout", timeout, 1'b0);
        end
        rst_n = 1'b1;

        prev = 0;
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].req, tbl[i].cmd, tbl[i].exp_w, 0, 0, 1'b0);
            if (i > 0) chk("wr_spacing", grant_cyc - prev, 3);
            prev = grant_cyc;
        end

        txn(4'b0100, 4'b0000, 2, 0, 2, 1'b0);
        txn(4'b0010, 4'b0000, 1, 99, 0, 1'b0);
        txn(4'b0110, 4'hF, 2, 0, 0, 1'b0);

        m_req = 4'b0100;
        m_cmd = 4'b0000;
        tick();
        chk("mr_grant", grant, 4'b0100);
        s_ack = 1'b1;
        #1;
        chk("mr_mack", m_ack, 4'b0100);
        tick();
        s_ack = 1'b0;
        #1;
        chk("mr_resp_grant", grant, 4'b0100);
        chk("mr_resp_sreq", s_req, 1'b0);
        rst_n = 1'b0;
        m_req = 4'b0000;
        tick();
        rst_n  = 1'b1;
        s_resp = 1'b1;
        #1;
        chk("mr_grant0", grant, 4'b0000);
        chk("mr_num", grant_num, 3'b100);
        chk("mr_sreq", s_req, 1'b0);
        chk("mr_late_resp", m_resp, 4'b0000);
        chk("mr_timeout", timeout, 1'b0);
        tick();
        s_resp = 1'b0;
        ptr = 0;
        txn(4'hF, 4'hF, 0, 0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            m_req  = 4'b0000;
            s_ack  = 1'b1;
            s_resp = 1'b1;
            #1;
            chk("stray_mack", m_ack, 4'b0000);
            chk("stray_mresp", m_resp, 4'b0000);
            chk("stray_sreq", s_req, 1'b0);
            chk("stray_grant", grant, 4'b0000);
            tick();
        end
        s_ack  = 1'b0;
        s_resp = 1'b0;
        txn(4'b0001, 4'hF, 0, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(1'b1);
            end else begin
                rq = 4'($urandom_range(1, 15));
                w  = winner(ptr, rq);
                txn(rq, 4'($urandom), w, int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_tot);
        $fatal(1, "watchdog");
    end

endmodule
